// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : Decode-to-execute stage for the RV64I/Zba core. It drives the
//               register-file read ports and resolves RAW hazards by
//               forwarding from EX and WB. It stalls on a load-use hazard and
//               registers the resolved operands into a single-entry
//               valid/ready slot that the execute stage consumes.
// Ports       : clk/rst_n     - clock, asynchronous active-low reset
//               flush         - kill stage contents (redirect)
//               in_*          - decoded instruction, valid/ready handshake
//               rf_*          - register-file combinational read ports
//               ex_fwd_*      - EX-stage forward / load-hazard source
//               wb_fwd_*      - WB-stage forward (same-cycle RF write)
//               out_*         - registered payload, valid/ready to EX
//               stall_cycles  - load-use stall count (optional feature)
// Options     : define OPFETCH_STALL_CNT_EN to build the saturating stall
//               counter; otherwise stall_cycles is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_stage #(
    parameter int XLEN        = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_imm,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [4:0]             in_rd,
    input  logic                   in_uses_rs1,
    input  logic                   in_uses_rs2,
    input  logic                   in_wen,
    input  logic                   in_is_load,
    output logic [4:0]             rf_rs1_addr,
    output logic [4:0]             rf_rs2_addr,
    input  logic [XLEN-1:0]        rf_rs1_data,
    input  logic [XLEN-1:0]        rf_rs2_data,
    input  logic                   ex_fwd_valid,
    input  logic [4:0]             ex_fwd_rd,
    input  logic [XLEN-1:0]        ex_fwd_data,
    input  logic                   ex_fwd_is_load,
    input  logic                   wb_fwd_valid,
    input  logic [4:0]             wb_fwd_rd,
    input  logic [XLEN-1:0]        wb_fwd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_imm,
    output logic [XLEN-1:0]        out_rs1_val,
    output logic [XLEN-1:0]        out_rs2_val,
    output logic [4:0]             out_rd,
    output logic                   out_wen,
    output logic                   out_is_load,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic            w_hazard;
    logic            w_accept;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    assign rf_rs1_addr = in_rs1;
    assign rf_rs2_addr = in_rs2;

    // Operand resolution. A load in EX has no data yet, so it is skipped here
    // and the hazard logic holds the instruction until the load reaches WB.
    // WB beats the register file because the RF has no write-through bypass.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_data
    );
        logic [XLEN-1:0] val;
        val = rf_data;
        if (idx == 5'd0)
            val = '0;
        else if (ex_fwd_valid && (ex_fwd_rd == idx) && !ex_fwd_is_load)
            val = ex_fwd_data;
        else if (wb_fwd_valid && (wb_fwd_rd == idx))
            val = wb_fwd_data;
        return val;
    endfunction

    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        w_rs1_val = resolve(in_rs1, rf_rs1_data);
        w_rs2_val = resolve(in_rs2, rf_rs2_data);
    end

    // Only sources the instruction really reads can create a load-use stall.
    assign w_hazard = in_valid && ex_fwd_valid && ex_fwd_is_load &&
                      (ex_fwd_rd != 5'd0) &&
                      ((in_uses_rs1 && (in_rs1 == ex_fwd_rd)) ||
                       (in_uses_rs2 && (in_rs2 == ex_fwd_rd)));

    assign in_ready = !w_hazard && !flush && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Operands are captured once at accept; a held entry is never
    // re-forwarded because all older producers have resolved by then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_wen     <= 1'b0;
            out_is_load <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_imm     <= in_imm;
            out_rs1_val <= w_rs1_val;
            out_rs2_val <= w_rs2_val;
            out_rd      <= in_rd;
            out_wen     <= in_wen;
            out_is_load <= in_is_load;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef OPFETCH_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_hazard && !flush && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_stage
// Description : Directed self-checking bench for operand_fetch_stage with a
//               behavioural register file and hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch_stage;

    localparam int XLEN = 64;
    localparam int SCW  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc, in_imm;
    logic [4:0]      in_rs1, in_rs2, in_rd;
    logic            in_uses_rs1, in_uses_rs2, in_wen, in_is_load;
    logic [4:0]      rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
    logic            ex_fwd_valid, ex_fwd_is_load;
    logic [4:0]      ex_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data;
    logic            wb_fwd_valid;
    logic [4:0]      wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_data;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_pc, out_imm, out_rs1_val, out_rs2_val;
    logic [4:0]      out_rd;
    logic            out_wen, out_is_load;
    logic [SCW-1:0]  stall_cycles;

    logic [XLEN-1:0] rf [32];
    int n_checks = 0;
    int n_errors = 0;

    assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? '0 : rf[rf_rs1_addr];
    assign rf_rs2_data = (rf_rs2_addr == 5'd0) ? '0 : rf[rf_rs2_addr];

    always #5 clk = ~clk;

    operand_fetch_stage #(.XLEN(XLEN), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_wen(in_wen), .in_is_load(in_is_load),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd),
        .ex_fwd_data(ex_fwd_data), .ex_fwd_is_load(ex_fwd_is_load),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd),
        .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_wen(out_wen), .out_is_load(out_is_load),
        .stall_cycles(stall_cycles)
    );

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [63:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_imm      = pc + 64'h8;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_rd       = 5'd10;
        in_uses_rs1 = u1;
        in_uses_rs2 = u2;
        in_wen      = 1'b1;
        in_is_load  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
        rf[5] = 64'h11; rf[6] = 64'h22; rf[7] = 64'hCCCC; rf[3] = 64'h9999;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_wen = 1'b0; in_is_load = 1'b0;
        ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0; ex_fwd_is_load = 1'b0;
        wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;

        // Reset state
        tick();
        check_val("rst_out_valid", 64'(out_valid), 64'h0);
        check_val("rst_out_pc", out_pc, 64'h0);
        check_val("rst_out_rs1", out_rs1_val, 64'h0);
        check_val("rst_stall", 64'(stall_cycles), 64'h0);
        rst_n = 1'b1;
        tick();

        // Single instruction from the register file
        instr(64'h100, 5'd5, 5'd6, 1'b1, 1'b1);
        #1;
        check_val("rf_addr1", 64'(rf_rs1_addr), 64'd5);
        check_val("rf_addr2", 64'(rf_rs2_addr), 64'd6);
        check_val("single_in_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check_val("single_valid", 64'(out_valid), 64'h1);
        check_val("single_rs1", out_rs1_val, 64'h11);
        check_val("single_rs2", out_rs2_val, 64'h22);
        check_val("single_pc", out_pc, 64'h100);
        check_val("single_imm", out_imm, 64'h108);
        check_val("single_rd", 64'(out_rd), 64'd10);
        tick();
        check_val("single_drain", 64'(out_valid), 64'h0);

        // Forward priority: EX over WB over RF, x0 always zero
        instr(64'h110, 5'd7, 5'd0, 1'b1, 1'b0);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd7; ex_fwd_data = 64'hAAAA;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 64'hBBBB;
        tick();
        check_val("fwd_ex", out_rs1_val, 64'hAAAA);
        ex_fwd_valid = 1'b0;
        in_pc = 64'h114;
        tick();
        check_val("fwd_wb", out_rs1_val, 64'hBBBB);
        check_val("fwd_b2b_pc", out_pc, 64'h114);
        in_rs1 = 5'd0; in_pc = 64'h118;
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 64'h5555;
        wb_fwd_rd = 5'd0;
        tick();
        check_val("fwd_x0", out_rs1_val, 64'h0);
        // EX load on an unused source: no stall, operand from RF
        in_rs1 = 5'd7; in_uses_rs1 = 1'b0; in_pc = 64'h11C;
        ex_fwd_rd = 5'd7; ex_fwd_is_load = 1'b1; wb_fwd_valid = 1'b0;
        #1;
        check_val("unused_no_hazard", 64'(in_ready), 64'h1);
        tick();
        check_val("fwd_rf", out_rs1_val, 64'hCCCC);
        in_valid = 1'b0; ex_fwd_valid = 1'b0; ex_fwd_is_load = 1'b0;
        tick();

        // Load-use stall, then operand from WB
        rf[1] = 64'h1;
        instr(64'h120, 5'd1, 5'd3, 1'b1, 1'b1);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd3; ex_fwd_is_load = 1'b1;
        #1;
        check_val("lu_stall_ready", 64'(in_ready), 64'h0);
        tick();
        check_val("lu_no_accept", 64'(out_valid), 64'h0);
        ex_fwd_valid = 1'b0; ex_fwd_is_load = 1'b0;
        wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 64'h1234;
        #1;
        check_val("lu_release_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0; wb_fwd_valid = 1'b0;
        check_val("lu_valid", 64'(out_valid), 64'h1);
        check_val("lu_rs2_wb", out_rs2_val, 64'h1234);
        check_val("lu_rs1", out_rs1_val, 64'h1);
`ifdef OPFETCH_STALL_CNT_EN
        check_val("lu_stall_cnt", 64'(stall_cycles), 64'h1);
`else
        check_val("lu_stall_cnt_off", 64'(stall_cycles), 64'h0);
`endif
        tick();

        // Back-pressure: payload held, no re-forwarding, then no bubble
        instr(64'h200, 5'd5, 5'd6, 1'b1, 1'b1);
        out_ready = 1'b0;
        tick();
        instr(64'h204, 5'd6, 5'd5, 1'b1, 1'b1);
        rf[5] = 64'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("bp_in_ready", 64'(in_ready), 64'h0);
            tick();
            check_val("bp_valid", 64'(out_valid), 64'h1);
            check_val("bp_pc", out_pc, 64'h200);
            check_val("bp_rs1_held", out_rs1_val, 64'h11);
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 64'(in_ready), 64'h1);
        tick();
        check_val("b2b_valid", 64'(out_valid), 64'h1);
        check_val("b2b_pc", out_pc, 64'h204);
        check_val("b2b_rs2", out_rs2_val, 64'h77);

        // Flush with slot valid and EX stalled, new input present
        out_ready = 1'b0;
        instr(64'h300, 5'd5, 5'd6, 1'b1, 1'b1);
        flush = 1'b1;
        #1;
        check_val("flush_in_ready", 64'(in_ready), 64'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_val("flush_valid", 64'(out_valid), 64'h0);
        tick();
        check_val("flush_not_taken", 64'(out_valid), 64'h0);

        // Async reset while the slot is full and a load-use stall is active
        instr(64'h400, 5'd3, 5'd6, 1'b1, 1'b1);
        tick();
        check_val("ar_fill", 64'(out_valid), 64'h1);
        ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd3; ex_fwd_is_load = 1'b1;
        tick();
`ifdef OPFETCH_STALL_CNT_EN
        check_val("ar_stall_cnt", 64'(stall_cycles), 64'h2);
`else
        check_val("ar_stall_cnt_off", 64'(stall_cycles), 64'h0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_valid", 64'(out_valid), 64'h0);
        check_val("ar_pc", out_pc, 64'h0);
        check_val("ar_stall", 64'(stall_cycles), 64'h0);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b0; ex_fwd_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute pipeline stage for the RV64I/Zba core.
- Drives the register file's two combinational read ports and resolves RAW hazards by forwarding from EX and WB.
- Stalls on load-use hazards.
- Registers the resolved operands into a single-entry valid/ready pipeline slot consumed by the execute stage.

Parameters:
- XLEN, 64, data and PC width.
- STALL_CNT_W, 32, width of the optional stall counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  active-low asynchronous reset
- flush  input  1  kill the stage contents (branch/trap redirect)
- in_valid  input  1  decoded instruction present
- in_ready  output  1  stage accepts the instruction this cycle
- in_pc  input  XLEN  instruction PC
- in_imm  input  XLEN  sign-extended immediate
- in_rs1, in_rs2, in_rd  input  5 each  register indices
- in_uses_rs1, in_uses_rs2  input  1 each  source operand is actually read
- in_wen  input  1  instruction writes rd
- in_is_load  input  1  instruction is a load
- rf_rs1_addr, rf_rs2_addr  output  5 each  register-file read addresses
- rf_rs1_data, rf_rs2_data  input  XLEN each  register-file read data (combinational, x0 reads 0)
- ex_fwd_valid  input  1  EX holds a writing instruction
- ex_fwd_rd  input  5  EX destination
- ex_fwd_data  input  XLEN  EX result
- ex_fwd_is_load  input  1  EX instruction is a load (data not yet available)
- wb_fwd_valid  input  1  WB writing this cycle (same signal as the register-file write enable)
- wb_fwd_rd  input  5  WB destination
- wb_fwd_data  input  XLEN  WB data
- out_valid  output  1  operands valid to EX
- out_ready  input  1  EX accepts
- out_pc, out_imm, out_rs1_val, out_rs2_val  output  XLEN each  registered payload
- out_rd  output  5  registered destination index
- out_wen, out_is_load  output  1 each  registered control bits
- stall_cycles  output  STALL_CNT_W  load-use stall count (optional feature only)

Behaviour:
- Reset (async, rst_n low): all out_* are 0, out_valid is 0, and stall_cycles is 0. Reset asserted mid-transfer discards the slot.
- rf_rs1_addr = in_rs1 and rf_rs2_addr = in_rs2, combinationally and unconditionally.
- Operand select per source, in priority order:
  - index 0 → 0.
  - ex_fwd_valid && ex_fwd_rd == idx && !ex_fwd_is_load → ex_fwd_data.
  - wb_fwd_valid && wb_fwd_rd == idx → wb_fwd_data. This covers a same-cycle register-file write, since the register file has no internal bypass.
  - Otherwise → rf data.
- Load-use hazard: `hazard = in_valid && ex_fwd_valid && ex_fwd_is_load && ex_fwd_rd != 0 && ((in_uses_rs1 && in_rs1 == ex_fwd_rd) || (in_uses_rs2 && in_rs2 == ex_fwd_rd))`.
- Handshake: `in_ready = !hazard && !flush && (!out_valid || out_ready)`. An instruction is accepted when in_valid && in_ready.
- Slot update (one state bit, out_valid), in priority order:
  - flush → out_valid := 0. Any input is not accepted.
  - accept → payload and resolved operands are captured, and out_valid := 1. Latency is 1 cycle from accept to out_valid.
  - out_valid && out_ready && !accept → out_valid := 0.
  - Otherwise → hold; payload is stable while out_valid && !out_ready.
- Full throughput: accept and drain occur in the same cycle when out_ready = 1.
- Hazard with EX back-pressure: in_ready stays 0 until the load reaches WB. The operand is then taken from the WB forward path.
- Operands are sampled only at accept and never re-forwarded while held. This is correct because every older producer has already resolved by that point.
- When in_uses_rsN = 0 the operand is still muxed, but it never triggers a hazard.

Optional Feature:
- Macro OPFETCH_STALL_CNT_EN.
- Defined: stall_cycles increments by 1 (saturating at all ones) on each cycle where hazard && !flush. It resets to 0.
- Undefined: stall_cycles is tied to 0 and no counter flops are generated.

Test Plan:
- Reset then a single instruction: rs1=5 (rf=0x11), rs2=6 (rf=0x22), out_ready=1 → next cycle out_valid=1, out_rs1_val=0x11, out_rs2_val=0x22; the cycle after, out_valid=0.
- Forward priority: rs1=7, EX rd=7 data=0xAAAA (non-load), WB rd=7 data=0xBBBB, rf=0xCCCC → out_rs1_val=0xAAAA. With EX invalid → 0xBBBB. rs1=0 with EX rd=0 → 0.
- Load-use: EX load rd=3, next instruction uses rs2=3 → in_ready=0 for 1 cycle. The next cycle WB rd=3 data=0x1234 → accepted, out_rs2_val=0x1234. Stall counter = 1 when OPFETCH_STALL_CNT_EN is defined.
- Back-pressure: out_ready=0 for 3 cycles after accept → out_valid and payload constant, in_ready=0. out_ready=1 with in_valid=1 → back-to-back transfer with no bubble.
- Flush: slot valid with out_ready=0 and flush=1 while in_valid=1 → next cycle out_valid=0 and the input is not accepted.
- Async reset mid-stall: rst_n low with out_valid=1 → out_valid=0 immediately, before any clock edge; stall_cycles=0.
